dmem_responder: RTL and testbench

- Multi-cycle data-memory responder: the target end of the load/store interface driven by the EXE_DM pipeline stage.
- Accepts one read or write request at a time over a valid/ready handshake.
- Models a fixed access latency with a countdown counter, and asserts stall so the core holds the DM stage until the response arrives.
- Replaces the single-cycle data memory when slow memory timing must be exercised.

---
 rtl/dmem_responder_pkg.sv | 15 +
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// The FSM state encoding and latency counter width are fixed here.
package dmem_responder_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int ISIZE_DEF = 16;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store handshake between the EXE_DM stage (master) and the responder (slave).
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ISIZE = ISIZE_DEF
);

  logic             req_valid;
  logic             req_write;
  logic [ISIZE-1:0] req_addr;
  logic [DSIZE-1:0] req_wdata;
  logic             req_ready;
  logic             resp_valid;
  logic [DSIZE-1:0] resp_rdata;
  logic             resp_err;
  logic             stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Word storage with synchronous write and registered read; rdata holds
// its value until the next read-enabled edge.
module dmem_array #(
  parameter int DSIZE  = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DSIZE-1:0]  wdata,
  output logic [DSIZE-1:0]  rdata
);

  logic [DSIZE-1:0] mem [2**AWIDTH];
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // NOTE: the storage has no reset; clearing an array costs a write port
  // per word, and software must not rely on its power-up contents anyway.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one load/store at a time, counts
// out a fixed latency while stalling the core, then pulses a response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int ISIZE   = ISIZE_DEF,
  parameter int AWIDTH  = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [ISIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             zero_q, zero_d;
  logic             addr_err;
  logic             mem_we, mem_re;
  logic [DSIZE-1:0] mem_rdata;

  assign addr_err = |addr_q[ISIZE-1:AWIDTH];

  // NOTE: every signal gets its default before the case, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    zero_d  = zero_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          mem_we  = write_q & ~addr_err;
          mem_re  = ~write_q & ~addr_err;
          // Only a completed read changes what resp_rdata shows afterwards.
          if (!write_q) zero_d = addr_err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      zero_q  <= zero_d;
    end
  end

  dmem_array #(
    .DSIZE  (DSIZE),
    .AWIDTH (AWIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (addr_q[AWIDTH-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) & addr_err;
  assign bus.stall      = ((state_q == IDLE) & bus.req_valid) | (state_q == WAIT);

  // Writes show zero during their own RESP, then the last read value returns.
  assign bus.resp_rdata = (zero_q || ((state_q == RESP) && write_q)) ? '0 : mem_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance driven by
// table vectors, hand sequences for reset corner cases, and random traffic.
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        drv_write = 1'b0;
  logic [15:0] drv_addr  = '0;
  logic [15:0] drv_wdata = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.DSIZE(16), .ISIZE(16)) bus0 ();
  dmem_responder_if #(.DSIZE(16), .ISIZE(16)) bus1 ();

  assign bus0.req_valid = v0;
  assign bus0.req_write = drv_write;
  assign bus0.req_addr  = drv_addr;
  assign bus0.req_wdata = drv_wdata;
  assign bus1.req_valid = v1;
  assign bus1.req_write = drv_write;
  assign bus1.req_addr  = drv_addr;
  assign bus1.req_wdata = drv_wdata;

  dmem_responder #(.DSIZE(16), .ISIZE(16), .AWIDTH(8), .LATENCY(LAT0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dmem_responder #(.DSIZE(16), .ISIZE(16), .AWIDTH(8), .LATENCY(LAT1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    int          sel;
    logic        w;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  // Reference memory: key = instance * 65536 + word address.
  logic [15:0] mdl [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic sample(input int sel, output logic rdy, output logic rv, output logic st,
                        output logic [15:0] rd, output logic er);
    if (sel == 0) begin
      rdy = bus0.req_ready; rv = bus0.resp_valid; st = bus0.stall;
      rd  = bus0.resp_rdata; er = bus0.resp_err;
    end else begin
      rdy = bus1.req_ready; rv = bus1.resp_valid; st = bus1.stall;
      rd  = bus1.resp_rdata; er = bus1.resp_err;
    end
  endtask

  // Presents one request from an IDLE cycle and follows it to its response.
  // req_valid is left high afterwards, as a core holding EXE_DM would.
  task automatic run_req(input int sel, input logic w, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd,
                         input logic exp_err, input string tag);
    int acc_idx = -1, resp_idx = -1, stall_n = 0, k = 0, lat;
    logic ready_bad = 1'b0, st_resp = 1'b0, done = 1'b0;
    logic rdy, rv, st, er, got_er = 1'b0;
    logic [15:0] rd, got_rd = '0;
    lat = (sel == 0) ? LAT0 : LAT1;
    @(negedge clk);
    drv_write = w; drv_addr = a; drv_wdata = d;
    v0 = (sel == 0); v1 = (sel == 1);
    while (!done && k < 40) begin
      #1;
      sample(sel, rdy, rv, st, rd, er);
      if (st) stall_n++;
      if (acc_idx >= 0 && rdy) ready_bad = 1'b1;
      if (rv) begin
        resp_idx = k; got_rd = rd; got_er = er; st_resp = st; done = 1'b1;
      end else begin
        if (acc_idx < 0 && rdy) acc_idx = k;
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_resp_seen"}, 32'(done), 32'd1);
    check({tag, "_accept_idx"}, 32'(acc_idx), 32'd0);
    check({tag, "_latency"}, 32'(resp_idx - acc_idx), 32'(lat + 1));
    check({tag, "_stall_cycles"}, 32'(stall_n), 32'(lat + 1));
    check({tag, "_stall_in_resp"}, 32'(st_resp), 32'd0);
    check({tag, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({tag, "_rdata"}, 32'(got_rd), 32'(exp_rd));
    check({tag, "_err"}, 32'(got_er), 32'(exp_err));
  endtask

  initial begin
    logic rdy, rv, st, er;
    logic [15:0] rd;
    int pulses;
    int s, key;
    logic w;
    logic [15:0] a, d, erd;
    logic eerr;

    vecs[0]  = '{0, 1'b1, 16'h0012, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 16'h0012, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{0, 1'b1, 16'h0001, 16'h1111, 16'h0000, 1'b0};
    vecs[3]  = '{0, 1'b0, 16'h0001, 16'h0000, 16'h1111, 1'b0};
    vecs[4]  = '{0, 1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[5]  = '{0, 1'b1, 16'h0100, 16'hAAAA, 16'h0000, 1'b1};
    vecs[6]  = '{0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0};
    vecs[7]  = '{0, 1'b0, 16'hFF00, 16'h0000, 16'h0000, 1'b1};
    vecs[8]  = '{0, 1'b1, 16'h00FF, 16'hCAFE, 16'h0000, 1'b0};
    vecs[9]  = '{0, 1'b0, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0};
    vecs[10] = '{0, 1'b1, 16'h0003, 16'h7777, 16'h0000, 1'b0};
    vecs[11] = '{1, 1'b1, 16'h0040, 16'h4242, 16'h0000, 1'b0};
    vecs[12] = '{1, 1'b0, 16'h0040, 16'h0000, 16'h4242, 1'b0};
    vecs[13] = '{1, 1'b1, 16'h0240, 16'h0BAD, 16'h0000, 1'b1};
    vecs[14] = '{1, 1'b0, 16'h0040, 16'h0000, 16'h4242, 1'b0};

    // Reset state, then idle cycles with req_valid low.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready0", 32'(bus0.req_ready), 32'd1);
    check("rst_ready1", 32'(bus1.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
    check("rst_rdata", 32'(bus0.resp_rdata), 32'd0);
    check("rst_err", 32'(bus0.resp_err), 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus0.resp_valid || bus0.stall || !bus0.req_ready) pulses++;
    end
    check("idle_quiet", 32'(pulses), 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i].sel, vecs[i].w, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
      if (vecs[i].w && vecs[i].addr < 16'd256)
        mdl[vecs[i].sel * 65536 + int'(vecs[i].addr)] = vecs[i].wdata;
    end

    // Reset during WAIT of a write: nothing committed, no response.
    @(negedge clk);
    drv_write = 1'b1; drv_addr = 16'h0003; drv_wdata = 16'h5555;
    v0 = 1'b1; v1 = 1'b0;
    #1;
    check("abort_stall_idle", 32'(bus0.stall), 32'd1);
    @(negedge clk); #1;
    check("abort_in_wait", 32'(bus0.req_ready), 32'd0);
    #2;
    rst = 1'b0; v0 = 1'b0;
    #1;
    check("abort_ready", 32'(bus0.req_ready), 32'd1);
    check("abort_no_resp", 32'(bus0.resp_valid), 32'd0);
    check("abort_stall", 32'(bus0.stall), 32'd0);
    check("abort_rdata_zero", 32'(bus0.resp_rdata), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus0.resp_valid) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    run_req(0, 1'b0, 16'h0003, 16'h0000, 16'h7777, 1'b0, "abort_readback");
    @(negedge clk);
    v0 = 1'b0;
    #1;
    check("rdata_hold", 32'(bus0.resp_rdata), 32'h7777);
    check("hold_no_resp", 32'(bus0.resp_valid), 32'd0);

    // Random traffic on both instances against the reference memory.
    for (int n = 0; n < 60; n++) begin
      s = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
      else a = 16'($urandom_range(0, 15));
      d = 16'($urandom);
      key = s * 65536 + int'(a);
      if (!w && a < 16'd256 && !mdl.exists(key)) w = 1'b1;
      if (a >= 16'd256) begin
        erd = '0; eerr = 1'b1;
      end else begin
        erd = w ? 16'h0000 : mdl[key];
        eerr = 1'b0;
      end
      run_req(s, w, a, d, erd, eerr, $sformatf("rnd%0d", n));
      if (w && a < 16'd256) mdl[key] = d;
    end

    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
